// File: rtl/signal_shrink_pkg.sv
// signal_shrink_pkg
// Shared types and constants for the signal_shrink receiver.
//   state_t         : FSM state encoding (IDLE / MEAS / WAIT_LOW), 2 bits
//   DEFAULT_TOL_CYC : default +/- width tolerance around the nominal width
package signal_shrink_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEAS     = 2'd1,
    WAIT_LOW = 2'd2
  } state_t;

  localparam int DEFAULT_TOL_CYC = 2;

endpackage

// File: rtl/signal_sync_2ff.sv
// signal_sync_2ff
// Single-bit two-flop synchronizer with asynchronous active-low reset.
// Both flops reset to 0.
// Ports:
//   i_clk   : destination clock
//   i_rst_n : asynchronous active-low reset
//   i_d     : asynchronous input bit
//   o_q     : synchronized output bit
module signal_sync_2ff (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic meta_reg;
  logic sync_reg;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      meta_reg <= 1'b0;
      sync_reg <= 1'b0;
    end else begin
      meta_reg <= i_d;
      sync_reg <= meta_reg;
    end
  end

  assign o_q = sync_reg;

endmodule

// File: rtl/signal_shrink.sv
// signal_shrink
// Recovers a single-cycle valid pulse (plus data bit) from a level-stretched
// valid, qualifying the stretched width against [MIN_CYC_NUM, MAX_CYC_NUM].
// Optional macro SIGNAL_SHRINK_SYNC_EN: when defined, i_vld and i_vld_data
// each pass through a 2-flop synchronizer (2 cycles extra latency).
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_vld          : stretched valid level
//   i_vld_data     : data bit, constant while i_vld is high
//   o_vld          : one-cycle recovered valid pulse
//   o_vld_data     : recovered data, valid with o_vld
//   o_err_short    : pulse, window narrower than MIN_CYC_NUM
//   o_err_long     : pulse, window wider than MAX_CYC_NUM
//   o_err_data     : pulse, data changed inside the window
//   o_width        : measured width with any result pulse, else 0
//   o_busy         : high while measuring or waiting for input low
module signal_shrink
  import signal_shrink_pkg::*;
#(
  parameter  int EXTEND_CYC_NUM = 12,
  parameter  int MIN_CYC_NUM    = EXTEND_CYC_NUM - DEFAULT_TOL_CYC,
  parameter  int MAX_CYC_NUM    = EXTEND_CYC_NUM + DEFAULT_TOL_CYC,
  localparam int CNT_W          = $clog2(MAX_CYC_NUM + 2)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_vld,
  input  logic             i_vld_data,
  output logic             o_vld,
  output logic             o_vld_data,
  output logic             o_err_short,
  output logic             o_err_long,
  output logic             o_err_data,
  output logic [CNT_W-1:0] o_width,
  output logic             o_busy
);

  logic vld_in;
  logic vld_data_in;

`ifdef SIGNAL_SHRINK_SYNC_EN
  logic [1:0] raw_bits;
  logic [1:0] sync_bits;

  assign raw_bits = {i_vld_data, i_vld};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sync
      signal_sync_2ff u_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (raw_bits[gi]),
        .o_q     (sync_bits[gi])
      );
    end
  endgenerate

  assign vld_in      = sync_bits[0];
  assign vld_data_in = sync_bits[1];
`else
  assign vld_in      = i_vld;
  assign vld_data_in = i_vld_data;
`endif

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MIN  = CNT_W'(MIN_CYC_NUM);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_CYC_NUM);
  localparam logic [CNT_W-1:0] CNT_OVER = CNT_W'(MAX_CYC_NUM + 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             data_reg, data_next;
  logic             mism_reg, mism_next;

  logic             vld_next, vld_data_next;
  logic             err_short_next, err_long_next, err_data_next;
  logic [CNT_W-1:0] width_next;
  logic             busy_next;

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    data_next      = data_reg;
    mism_next      = mism_reg;
    vld_next       = 1'b0;
    vld_data_next  = 1'b0;
    err_short_next = 1'b0;
    err_long_next  = 1'b0;
    err_data_next  = 1'b0;
    width_next     = '0;

    case (state_reg)
      IDLE: begin
        if (vld_in) begin
          state_next = MEAS;
          cnt_next   = CNT_ONE;
          data_next  = vld_data_in;
          mism_next  = 1'b0;
        end
      end

      MEAS: begin
        if (vld_in) begin
          if (cnt_reg == CNT_MAX) begin
            // Too wide: report once, then swallow the rest of the window.
            err_long_next = 1'b1;
            width_next    = CNT_OVER;
            state_next    = WAIT_LOW;
          end else begin
            cnt_next = cnt_reg + CNT_ONE;
            if (vld_data_in != data_reg) begin
              mism_next = 1'b1;
            end
          end
        end else begin
          // Falling edge: exactly one result, short beats data error.
          width_next = cnt_reg;
          state_next = IDLE;
          if (cnt_reg < CNT_MIN) begin
            err_short_next = 1'b1;
          end else if (mism_reg) begin
            err_data_next = 1'b1;
          end else begin
            vld_next      = 1'b1;
            vld_data_next = data_reg;
          end
        end
      end

      WAIT_LOW: begin
        if (!vld_in) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = WAIT_LOW;
      end
    endcase

    busy_next = (state_next != IDLE);
  end

  // Reset lands in WAIT_LOW so a window already in flight at release is
  // discarded rather than measured short.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg   <= WAIT_LOW;
      cnt_reg     <= '0;
      data_reg    <= 1'b0;
      mism_reg    <= 1'b0;
      o_vld       <= 1'b0;
      o_vld_data  <= 1'b0;
      o_err_short <= 1'b0;
      o_err_long  <= 1'b0;
      o_err_data  <= 1'b0;
      o_width     <= '0;
      o_busy      <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      data_reg    <= data_next;
      mism_reg    <= mism_next;
      o_vld       <= vld_next;
      o_vld_data  <= vld_data_next;
      o_err_short <= err_short_next;
      o_err_long  <= err_long_next;
      o_err_data  <= err_data_next;
      o_width     <= width_next;
      o_busy      <= busy_next;
    end
  end

endmodule

// File: tb/tb_signal_shrink.sv
// tb_signal_shrink
// Scoreboard bench for signal_shrink (default parameters, macro off).
// Each stimulus window pushes its expected result (kind, data, width, cycle)
// computed from the width/data rules; a negedge monitor pops and compares
// whenever a result pulse appears.
module tb_signal_shrink;

  localparam int EXT   = 12;
  localparam int MINC  = EXT - 2;
  localparam int MAXC  = EXT + 2;
  localparam int CNT_W = $clog2(MAXC + 2);

  logic             i_clk = 1'b0;
  logic             i_rst_n = 1'b0;
  logic             i_vld = 1'b0;
  logic             i_vld_data = 1'b0;
  logic             o_vld, o_vld_data, o_err_short, o_err_long, o_err_data;
  logic [CNT_W-1:0] o_width;
  logic             o_busy;

  signal_shrink dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_vld       (i_vld),
    .i_vld_data  (i_vld_data),
    .o_vld       (o_vld),
    .o_vld_data  (o_vld_data),
    .o_err_short (o_err_short),
    .o_err_long  (o_err_long),
    .o_err_data  (o_err_data),
    .o_width     (o_width),
    .o_busy      (o_busy)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  localparam int K_VLD = 0, K_SHORT = 1, K_LONG = 2, K_DATA = 3;

  typedef struct {
    int kind;
    int data;
    int width;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   txn = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called just after a posedge; first high sample is the next posedge.
  // flip_at > 0: samples with index >= flip_at carry the inverted data bit.
  task automatic drive_window(input int w, input bit d, input int flip_at, input int gap);
    exp_t e;
    int   s;
    bit   mism;
    s    = cyc + 1;
    mism = (flip_at > 0) && (flip_at < w);
    if (w > MAXC) begin
      e.kind = K_LONG; e.data = 0; e.width = MAXC + 1; e.cyc = s + MAXC;
    end else if (w < MINC) begin
      e.kind = K_SHORT; e.data = 0; e.width = w; e.cyc = s + w;
    end else if (mism) begin
      e.kind = K_DATA; e.data = 0; e.width = w; e.cyc = s + w;
    end else begin
      e.kind = K_VLD; e.data = int'(d); e.width = w; e.cyc = s + w;
    end
    sb.push_back(e);
    for (int i = 0; i < w; i++) begin
      i_vld      = 1'b1;
      i_vld_data = (flip_at > 0 && i >= flip_at) ? ~d : d;
      @(posedge i_clk); #1;
    end
    for (int i = 0; i < gap; i++) begin
      i_vld      = 1'b0;
      i_vld_data = 1'($urandom);
      @(posedge i_clk); #1;
    end
  endtask

  // Monitor
  always @(negedge i_clk) begin : mon
    int   npulse;
    int   kind;
    exp_t e;
    if (!i_rst_n) begin
      chk("reset_outputs_zero",
          int'({o_vld, o_vld_data, o_err_short, o_err_long, o_err_data, o_width, o_busy}), 0);
    end else begin
      npulse = int'(o_vld) + int'(o_err_short) + int'(o_err_long) + int'(o_err_data);
      if (sb.size() > 0 && cyc > sb[0].cyc) begin
        errors++; checks++;
        $display("FAIL missing_pulse: none at cycle %0d expected kind %0d", sb[0].cyc, sb[0].kind);
        void'(sb.pop_front());
      end
      if (npulse == 0) begin
        chk("idle_width_zero", int'(o_width), 0);
      end else begin
        chk("one_hot", npulse, 1);
        kind = o_vld ? K_VLD : o_err_short ? K_SHORT : o_err_long ? K_LONG : K_DATA;
        if (sb.size() == 0) begin
          errors++; checks++;
          $display("FAIL unexpected_pulse: kind %0d width %0d at cycle %0d, none required",
                   kind, o_width, cyc);
        end else begin
          e = sb.pop_front();
          txn++;
          $display("txn %0d cycle %0d kind %0d data %0d width %0d (want kind %0d data %0d width %0d cycle %0d)",
                   txn, cyc, kind, o_vld_data, o_width, e.kind, e.data, e.width, e.cyc);
          chk("kind", kind, e.kind);
          chk("width", int'(o_width), e.width);
          chk("cycle", cyc, e.cyc);
          if (e.kind == K_VLD) chk("vld_data", int'(o_vld_data), e.data);
        end
      end
    end
  end

  initial begin
    int cat, w, f;
    bit d;

    // Reset, then release with input low; one idle cycle before stimulus.
    repeat (3) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    @(negedge i_clk) chk("busy_idle", int'(o_busy), 0);
    @(posedge i_clk); #1;

    // Directed scenarios
    drive_window(12, 1'b1, -1, 2);   // nominal
    drive_window(1,  1'b0, -1, 2);   // glitch
    drive_window(20, 1'b1, -1, 2);   // stuck high
    drive_window(12, 1'b1, -1, 2);   // recovery
    drive_window(12, 1'b1, 6, 2);    // data flip
    drive_window(12, 1'b1, -1, 1);   // back-to-back
    drive_window(12, 1'b0, -1, 3);
    drive_window(MINC - 1, 1'b1, -1, 2);  // boundaries
    drive_window(MINC,     1'b0, -1, 2);
    drive_window(MAXC,     1'b1, -1, 2);
    drive_window(MAXC + 1, 1'b1, -1, 1);
    repeat (4) @(posedge i_clk);
    #1;

    // Reset mid-window: the whole window is discarded.
    for (int i = 0; i < 5; i++) begin
      i_vld = 1'b1; i_vld_data = 1'b1;
      @(posedge i_clk); #1;
    end
    i_rst_n = 1'b0;
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge i_clk); #1;
    end
    @(negedge i_clk) chk("busy_wait_low", int'(o_busy), 1);
    @(posedge i_clk); #1;
    i_vld = 1'b0;
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    drive_window(12, 1'b1, -1, 2);

    // Randomized windows
    for (int n = 0; n < 40; n++) begin
      cat = int'($urandom_range(0, 3));
      d   = 1'($urandom);
      f   = -1;
      case (cat)
        0: w = int'($urandom_range(1, MINC - 1));
        1: w = int'($urandom_range(MINC, MAXC));
        2: w = int'($urandom_range(MAXC + 1, MAXC + 6));
        default: begin
          w = int'($urandom_range(MINC, MAXC));
          f = int'($urandom_range(1, w - 1));
        end
      endcase
      drive_window(w, d, f, int'($urandom_range(1, 3)));
    end

    // Drain with a bounded wait.
    for (int i = 0; i < 40 && sb.size() > 0; i++) @(posedge i_clk);
    @(posedge i_clk);
    chk("scoreboard_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
